sobel_param_scheduler: RTL and testbench

SOBEL_PARAM_SCHEDULER -- requirements
Module: sobel_param_scheduler

---
 rtl/sobel_pkg.sv | 28 ++
 rtl/key_repeat_gen.sv | 46 ++++
 rtl/sobel_param_scheduler.sv | 132 +++++++++++++
 tb/tb_sobel_param_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared encodings and widths for the Sobel parameter scheduler.
package sobel_pkg;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned THR_W = 8;

    typedef enum logic [1:0] {
        MODE_RAW_GRAY  = 2'd0,
        MODE_SOBEL     = 2'd1,
        MODE_SOBEL_INV = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRTY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Cycle RAW_GRAY -> SOBEL -> SOBEL_INV -> RAW_GRAY; never yields 3.
    function automatic mode_e next_mode(input mode_e cur);
        case (cur)
            MODE_RAW_GRAY: next_mode = MODE_SOBEL;
            MODE_SOBEL:    next_mode = MODE_SOBEL_INV;
            default:       next_mode = MODE_RAW_GRAY;
        endcase
    endfunction

endpackage

// File: rtl/key_repeat_gen.sv
// Auto-repeat step generator for one held key; only instanced with SOBEL_AUTO_REPEAT_EN.
module key_repeat_gen
    import sobel_pkg::*;
#(
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic held,
    input  logic other_held,
    output logic step_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;

    // Count held cycles; first step after the initial delay, then every period.
    always_comb begin
        cnt_d  = cnt_q;
        rep_d  = rep_q;
        step_c = 1'b0;
        if (!(held && !other_held)) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (cnt_q == (rep_q ? REPEAT_PERIOD : REPEAT_DELAY)) begin
            step_c = 1'b1;
            cnt_d  = CNT_W'(1);
            rep_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rep_q <= rep_d;
        end
    end

endmodule

// File: rtl/sobel_param_scheduler.sv
// Threshold/mode shadow registers committed on frame boundaries.
// Optional auto-repeat of held keys: define SOBEL_AUTO_REPEAT_EN.
module sobel_param_scheduler
    import sobel_pkg::*;
#(
    parameter logic [THR_W-1:0] THRESH_INIT   = 8'd128,
    parameter logic [THR_W-1:0] THRESH_STEP   = 8'd10,
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic             clk_pixel_division,
    input  logic             rst_n,
    input  logic             inc_pulse,
    input  logic             dec_pulse,
    input  logic             inc_held,
    input  logic             dec_held,
    input  logic             mode_pulse,
    input  logic             vsync,
    output logic [THR_W-1:0] threshold,
    output logic [1:0]       mode,
    output logic             pending,
    output logic             commit_pulse
);

    logic rep_inc_c, rep_dec_c;

`ifdef SOBEL_AUTO_REPEAT_EN
    key_repeat_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rep_inc (
        .clk       (clk_pixel_division),
        .rst_n     (rst_n),
        .held      (inc_held),
        .other_held(dec_held),
        .step_c    (rep_inc_c)
    );

    key_repeat_gen #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_rep_dec (
        .clk       (clk_pixel_division),
        .rst_n     (rst_n),
        .held      (dec_held),
        .other_held(inc_held),
        .step_c    (rep_dec_c)
    );
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{inc_held, dec_held, REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_inc_c = 1'b0;
    assign rep_dec_c = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [THR_W-1:0] thr_sh_q, thr_sh_d, thr_q, thr_d;
    mode_e            mode_sh_q, mode_sh_d, mode_q, mode_d;
    logic             vsync_q, pending_q, pending_d, commit_q, commit_d;
    logic             inc_c, dec_c, event_c, frame_edge_c;

    // Shadow updates, commit FSM and registered outputs.
    always_comb begin
        inc_c        = inc_pulse | rep_inc_c;
        dec_c        = dec_pulse | rep_dec_c;
        event_c      = (inc_c ^ dec_c) | mode_pulse;
        frame_edge_c = vsync & ~vsync_q;

        thr_sh_d  = thr_sh_q;
        mode_sh_d = mode_sh_q;
        state_d   = state_q;
        thr_d     = thr_q;
        mode_d    = mode_q;
        commit_d  = 1'b0;

        if (inc_c && !dec_c) begin
            thr_sh_d = (thr_sh_q > (8'hFF - THRESH_STEP)) ? 8'hFF : thr_sh_q + THRESH_STEP;
        end else if (dec_c && !inc_c) begin
            thr_sh_d = (thr_sh_q < THRESH_STEP) ? 8'h00 : thr_sh_q - THRESH_STEP;
        end
        if (mode_pulse) begin
            mode_sh_d = next_mode(mode_sh_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (event_c) state_d = ST_DIRTY;
            end
            ST_DIRTY: begin
                if (frame_edge_c) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                thr_d    = thr_sh_q;
                mode_d   = mode_sh_q;
                commit_d = 1'b1;
                state_d  = event_c ? ST_DIRTY : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        pending_d = (state_d != ST_IDLE);
    end

    // All scheduler state, synchronous active-low reset.
    always_ff @(posedge clk_pixel_division) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            thr_sh_q  <= THRESH_INIT;
            mode_sh_q <= MODE_RAW_GRAY;
            thr_q     <= THRESH_INIT;
            mode_q    <= MODE_RAW_GRAY;
            vsync_q   <= 1'b1;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            thr_sh_q  <= thr_sh_d;
            mode_sh_q <= mode_sh_d;
            thr_q     <= thr_d;
            mode_q    <= mode_d;
            vsync_q   <= vsync;
            pending_q <= pending_d;
            commit_q  <= commit_d;
        end
    end

    assign threshold    = thr_q;
    assign mode         = 2'(mode_q);
    assign pending      = pending_q;
    assign commit_pulse = commit_q;

endmodule

// File: tb/tb_sobel_param_scheduler.sv
// Directed, table-driven bench for sobel_param_scheduler.
module tb_sobel_param_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_pulse = 1'b0, dec_pulse = 1'b0;
    logic       inc_held = 1'b0, dec_held = 1'b0;
    logic       mode_pulse = 1'b0, vsync = 1'b0;
    logic [7:0] threshold;
    logic [1:0] mode;
    logic       pending, commit_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    sobel_param_scheduler #(
        .THRESH_INIT  (8'd128),
        .THRESH_STEP  (8'd10),
        .REPEAT_DELAY (24'd100),
        .REPEAT_PERIOD(24'd20)
    ) dut (
        .clk_pixel_division(clk),
        .rst_n             (rst_n),
        .inc_pulse         (inc_pulse),
        .dec_pulse         (dec_pulse),
        .inc_held          (inc_held),
        .dec_held          (dec_held),
        .mode_pulse        (mode_pulse),
        .vsync             (vsync),
        .threshold         (threshold),
        .mode              (mode),
        .pending           (pending),
        .commit_pulse      (commit_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        int n_inc;
        int n_dec;
        int n_mode;
        int exp_thr;
        int exp_mode;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        inc_pulse = 0; dec_pulse = 0; mode_pulse = 0; vsync = 0;
        inc_held = 0; dec_held = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_n(input int n, input int which);
        for (int i = 0; i < n; i++) begin
            inc_pulse  = (which == 0);
            dec_pulse  = (which == 1);
            mode_pulse = (which == 2);
            tick();
            inc_pulse = 0; dec_pulse = 0; mode_pulse = 0;
        end
    endtask

    initial begin
        vecs[0] = '{3,  0,  0, 158, 0};
        vecs[1] = '{13, 0,  0, 255, 0};
        vecs[2] = '{0,  13, 0, 0,   0};
        vecs[3] = '{0,  0,  4, 128, 1};
        vecs[4] = '{2,  1,  0, 138, 0};
        vecs[5] = '{1,  1,  0, 128, 0};
        vecs[6] = '{0,  1,  2, 118, 2};
        vecs[7] = '{25, 1,  0, 245, 0};

        do_reset();
        chk("reset threshold", int'(threshold), 128);
        chk("reset mode", int'(mode), 0);
        chk("reset pending", int'(pending), 0);
        chk("reset commit_pulse", int'(commit_pulse), 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            tick();
            pulse_n(vecs[v].n_inc, 0);
            pulse_n(vecs[v].n_dec, 1);
            pulse_n(vecs[v].n_mode, 2);
            chk($sformatf("v%0d shadow", v), int'(dut.thr_sh_q), vecs[v].exp_thr);
            chk($sformatf("v%0d pending pre", v), int'(pending), 1);
            vsync = 1;
            tick();
            chk($sformatf("v%0d thr before commit", v), int'(threshold), 128);
            chk($sformatf("v%0d no early commit", v), int'(commit_pulse), 0);
            tick();
            chk($sformatf("v%0d threshold", v), int'(threshold), vecs[v].exp_thr);
            chk($sformatf("v%0d mode", v), int'(mode), vecs[v].exp_mode);
            chk($sformatf("v%0d commit_pulse", v), int'(commit_pulse), 1);
            vsync = 0;
            tick();
            chk($sformatf("v%0d commit one cycle", v), int'(commit_pulse), 0);
            chk($sformatf("v%0d pending post", v), int'(pending), 0);
        end

        // Simultaneous inc and dec are ignored.
        do_reset();
        inc_pulse = 1; dec_pulse = 1;
        tick();
        inc_pulse = 0; dec_pulse = 0;
        tick();
        chk("both shadow", int'(dut.thr_sh_q), 128);
        chk("both pending", int'(pending), 0);

        // Frame edge in IDLE: nothing happens.
        vsync = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle edge commit", int'(commit_pulse), 0);
        end
        chk("idle edge threshold", int'(threshold), 128);
        vsync = 0;

        // Event in the COMMIT cycle re-dirties.
        do_reset();
        tick();
        pulse_n(1, 0);
        vsync = 1;
        tick();
        inc_pulse = 1;
        tick();
        inc_pulse = 0;
        chk("commit-cycle threshold", int'(threshold), 138);
        chk("commit-cycle pulse", int'(commit_pulse), 1);
        chk("commit-cycle pending", int'(pending), 1);
        vsync = 0;
        tick();
        chk("commit-cycle shadow", int'(dut.thr_sh_q), 148);
        chk("commit-cycle no pulse", int'(commit_pulse), 0);
        vsync = 1;
        tick();
        tick();
        chk("second commit threshold", int'(threshold), 148);
        chk("second commit pulse", int'(commit_pulse), 1);
        vsync = 0;

        // Event in the frame-edge cycle is included in the commit.
        do_reset();
        tick();
        pulse_n(1, 0);
        vsync = 1; inc_pulse = 1;
        tick();
        inc_pulse = 0;
        tick();
        chk("edge-cycle event threshold", int'(threshold), 148);
        vsync = 0;

        // Reset while in COMMIT discards the shadow.
        do_reset();
        tick();
        pulse_n(2, 0);
        vsync = 1;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1; vsync = 0;
        chk("reset in commit threshold", int'(threshold), 128);
        chk("reset in commit shadow", int'(dut.thr_sh_q), 128);
        chk("reset in commit pending", int'(pending), 0);
        chk("reset in commit pulse", int'(commit_pulse), 0);

`ifdef SOBEL_AUTO_REPEAT_EN
        // Held key: press pulse plus repeats at 100, 120, 140 cycles.
        do_reset();
        tick();
        inc_pulse = 1; inc_held = 1;
        tick();
        inc_pulse = 0;
        for (int i = 0; i < 159; i++) tick();
        inc_held = 0;
        tick();
        chk("repeat shadow", int'(dut.thr_sh_q), 168);
        chk("repeat pending", int'(pending), 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("repeat reset threshold", int'(threshold), 128);
        chk("repeat reset pending", int'(pending), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
